// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: format tags, opcodes, field widths/offsets
// and the field bundle struct used by the encoder and decoder.
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_J    = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int SH_W  = 5;
  localparam int FN_W  = 6;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [SH_W-1:0]  shamt;
    logic [FN_W-1:0]  funct;
    logic [IMM_W-1:0] immediate;
    logic [TGT_W-1:0] target;
  } mips_fields_t;

endpackage

// File: rtl/mips_pack.sv
// Combinational field packer: {fmt, fields} -> 32-bit MIPS word.
// With MIPS_ENC_CHECK_EN defined, also flags opcode/format inconsistencies.
module mips_pack
  import mips_pkg::*;
(
  input  fmt_e         fmt,
  input  mips_fields_t f,
  output logic [31:0]  word,
  output logic         chk_fail
);

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {f.opcode, f.rs, f.rt, f.rd, f.shamt, f.funct};
      FMT_I:   word = {f.opcode, f.rs, f.rt, f.immediate};
      FMT_J:   word = {f.opcode, f.target};
      default: word = '0;
    endcase
  end

`ifdef MIPS_ENC_CHECK_EN
  always_comb begin
    chk_fail = 1'b0;
    case (fmt)
      FMT_R:   chk_fail = (f.opcode != OP_RTYPE);
      FMT_I:   chk_fail = (f.opcode == OP_RTYPE) || (f.opcode == OP_J) || (f.opcode == OP_JAL);
      FMT_J:   chk_fail = (f.opcode != OP_J) && (f.opcode != OP_JAL);
      default: chk_fail = 1'b0;
    endcase
  end
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs field bundles into words, stamps sequential
// addresses, one-entry output register. Optional checks via MIPS_ENC_CHECK_EN.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32,
  parameter int          MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              err
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_WORDS - 1);

  typedef enum logic {S_EMPTY, S_FULL} st_e;

  st_e              st;
  logic [IDX_W-1:0] idx, cur_idx, nxt_idx;
  mips_fields_t     fields;
  fmt_e             fmt_t;
  logic [31:0]      word;
  logic             chk_fail, xfer, drop, accept;

  assign fmt_t  = fmt_e'(fmt);
  assign fields = '{opcode: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt,
                    funct: funct, immediate: immediate, target: target};

  mips_pack u_pack (
    .fmt      (fmt_t),
    .f        (fields),
    .word     (word),
    .chk_fail (chk_fail)
  );

  assign in_ready = (st == S_EMPTY) || out_ready;
  assign xfer     = in_valid && in_ready;
  assign drop     = (fmt_t == FMT_RSVD) || chk_fail;
  assign accept   = xfer && !drop;

  // restart in the same cycle as a transfer gives that word index 0
  assign cur_idx = restart ? '0 : idx;
  assign nxt_idx = (cur_idx == IDX_LAST) ? '0 : cur_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_EMPTY;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= ADDR_W'(BASE_ADDR);
      out_last  <= 1'b0;
      err       <= 1'b0;
      idx       <= '0;
    end else begin
      if (xfer && drop) err <= 1'b1;
      if (accept) begin
        st        <= S_FULL;
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'({cur_idx, 2'b00});
        out_last  <= (cur_idx == IDX_LAST);
        idx       <= nxt_idx;
      end else begin
        if (restart) idx <= '0;
        if (st == S_FULL && out_ready) begin
          st        <= S_EMPTY;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder (MAX_WORDS=4 for wrap).
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, in_ready, out_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] target;
  logic        out_valid, out_last, err;
  logic [31:0] out_instr, out_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.BASE_ADDR(32'h0), .ADDR_W(32), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .immediate(immediate), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_last(out_last), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
    fmt = 2'd0; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    immediate = 16'hffff; target = '1;
  endtask

  task automatic set_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                       input logic [15:0] imm);
    fmt = 2'd1; opcode = op; rs = s; rt = t; immediate = imm;
    rd = 5'h1f; shamt = 5'h1f; funct = 6'h3f; target = '1;
  endtask

  task automatic set_j(input logic [5:0] op, input logic [25:0] tg);
    fmt = 2'd2; opcode = op; target = tg;
    rs = 5'h1f; rt = 5'h1f; rd = 5'h1f; shamt = 5'h1f; funct = 6'h3f; immediate = '1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; restart = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  logic [31:0] hold_i, hold_a;

  initial begin
    out_ready = 1'b1;
    set_r(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0);
    do_reset();

    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr",  out_addr, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_err",   err, 0);
    chk("rst_ready", in_ready, 1);

    // R-type
    set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r_valid", out_valid, 1);
    chk("r_instr", out_instr, 32'h0022_1905);
    chk("r_addr",  out_addr, 0);
    tick();
    chk("r_drain", out_valid, 0);

    // lw then j back-to-back
    do_reset();
    set_i(6'd35, 5'd1, 5'd2, 16'd3);
    in_valid = 1'b1;
    tick();
    chk("lw_instr", out_instr, 32'h8C22_0003);
    chk("lw_addr",  out_addr, 0);
    set_j(6'd2, 26'd3);
    chk("bb_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("j_valid", out_valid, 1);
    chk("j_instr", out_instr, 32'h0800_0003);
    chk("j_addr",  out_addr, 4);
    tick();
    chk("bb_drain", out_valid, 0);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5);
    in_valid = 1'b1;
    tick();
    set_i(6'd35, 5'd1, 5'd2, 16'd3);
    hold_i = 32'h0022_1905; hold_a = 32'd0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_instr", out_instr, hold_i);
      chk("bp_addr",  out_addr, hold_a);
      chk("bp_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_instr", out_instr, 32'h8C22_0003);
    chk("bp_b_addr",  out_addr, 4);
    tick();
    chk("bp_drain", out_valid, 0);

    // wrap at MAX_WORDS=4
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_j(6'd2, 26'(k));
      tick();
      chk("wrap_instr", out_instr, 32'h0800_0000 | k);
      chk("wrap_addr",  out_addr, (k % 4) * 4);
      chk("wrap_last",  out_last, (k == 3));
    end
    // counter is at index 1; restart with a transfer takes address 0
    restart = 1'b1;
    set_j(6'd3, 26'h55);
    tick();
    restart = 1'b0;
    chk("rs_addr",  out_addr, 0);
    chk("rs_instr", out_instr, 32'h0C00_0055);
    set_j(6'd2, 26'h66);
    tick();
    chk("rs_next_addr", out_addr, 4);
    in_valid = 1'b0;
    tick();

    // reserved format
    do_reset();
    fmt = 2'd3; opcode = 6'd0;
    in_valid = 1'b1;
    chk("rsvd_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("rsvd_valid", out_valid, 0);
    chk("rsvd_err",   err, 1);
    set_j(6'd2, 26'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rsvd_next_addr", out_addr, 0);
    chk("rsvd_next_valid", out_valid, 1);
    tick(); tick();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_clear", err, 0);

`ifdef MIPS_ENC_CHECK_EN
    set_r(6'd35, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("chk_r_valid", out_valid, 0);
    chk("chk_r_err",   err, 1);
    do_reset();
`endif

    // reset while FULL and stalled
    out_ready = 1'b0;
    set_j(6'd2, 26'd9);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    set_j(6'd2, 26'd10);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_rst_addr",  out_addr, 0);
    chk("mid_rst_instr", out_instr, 32'h0800_000A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the team's MIPS field decoder: accepts instruction fields plus a format tag and packs them into 32-bit MIPS words (R/I/J).
- Stamps each word with a sequential program address and hands it to the instruction-memory loader over a valid/ready stream.
- Used by the bench/bootloader path to build program images field-by-field.
- One-entry output register with backpressure; address counter with wrap.

Parameters:
- BASE_ADDR, 32'h0000_0000, address assigned to the first word after reset or restart.
- ADDR_W, 32, width of the address output and counter.
- MAX_WORDS, 1024, image capacity in words; the counter wraps to BASE_ADDR after MAX_WORDS words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- restart  in  1  one-cycle pulse: reload the address counter with BASE_ADDR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- fmt  in  2  format: 0=R, 1=I, 2=J, 3=reserved.
- opcode  in  6  instruction opcode.
- rs  in  5  source register.
- rt  in  5  target register.
- rd  in  5  destination register (R only).
- shamt  in  5  shift amount (R only).
- funct  in  6  function code (R only).
- immediate  in  16  immediate (I only).
- target  in  26  jump target (J only).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of the word.
- out_last  out  1  word occupies the final slot (index MAX_WORDS-1).
- err  out  1  sticky: reserved fmt was seen (plus the optional-feature errors).

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0, err=0, word counter=0. in_ready=1 in the cycle after reset.
- Packing rules:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, immediate}.
  - J: {opcode, target}.
  - Fields not used by a format are ignored.
- Input handshake: a transfer occurs on a rising edge with in_valid && in_ready. The encoded word is registered; out_valid rises the next cycle (latency 1).
- State machine:
  - EMPTY: in_ready=1, out_valid=0. On transfer, go to FULL.
  - FULL: out_valid=1, in_ready=out_ready (pass-through).
    - out_ready=1 with a new transfer in the same cycle: load the new word, stay FULL. This sustains 1 word/clk.
    - out_ready=1 with no transfer: go to EMPTY.
    - out_ready=0: hold all outputs stable.
- Address counter:
  - Increments by 4 on each accepted input.
  - out_addr = BASE_ADDR + 4*index; out_last = (index==MAX_WORDS-1).
  - After index MAX_WORDS-1 the next word gets index 0 (wrap). There is no stall at wrap.
- fmt=3: the bundle is consumed (in_ready handshake completes), no word is produced, the counter does not advance, and err is set.
- restart:
  - Takes effect at the clock edge. The next accepted word gets BASE_ADDR.
  - A word already held in FULL keeps its address.
  - If restart and a transfer occur in the same cycle, the transferred word gets BASE_ADDR and the counter becomes index 1.
- reset mid-operation: the held word is discarded and the block returns to EMPTY. err is cleared only by reset.
- out_instr/out_addr are don't-care when out_valid=0, but they are held at their last value.

Optional Feature:
- Macro: MIPS_ENC_CHECK_EN.
- Defined: format-consistency checks run on accepted bundles. Any violation drops the bundle exactly like fmt=3 (no word, no address advance, err set). Violations:
  - R with opcode!=0.
  - J with opcode not 2 or 3.
  - I with opcode 0, 2 or 3.
- Undefined: no checks; every R/I/J bundle is packed as given. err reflects only fmt=3.

Decomposition:
- Shared package mips_pkg:
  - format enum FMT_R/FMT_I/FMT_J/FMT_RSVD.
  - opcode constants OP_RTYPE=6'd0, OP_J=6'd2, OP_JAL=6'd3, OP_LW=6'd35, OP_SW=6'd43.
  - field width/offset constants shared with the decoder.
- Sub-module mips_pack: purely combinational {fmt, fields} -> 32-bit word, plus check-fail flag under the macro.
- Top level holds the FSM, output register and address counter.

Test Plan:
- R-type: fmt=0, op=0, rs=1, rt=2, rd=3, shamt=4, funct=5, out_ready=1 -> next cycle out_instr=32'h0022_1905, out_addr=0, out_valid=1.
- I-type then J-type back-to-back:
  - lw (op=35, rs=1, rt=2, imm=3) -> 32'h8C22_0003 at addr 0.
  - j (op=2, target=3) -> 32'h0800_0003 at addr 4.
  - One word per cycle, no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable. Release -> both words delivered in order, addresses 0 then 4.
- Wrap/restart:
  - MAX_WORDS=4, push 5 words -> addresses 0, 4, 8, 12 (out_last=1 on the 4th), then 0.
  - Pulse restart with a transfer -> that word gets address 0.
- Error: fmt=3 -> handshake completes, no out_valid, next word takes the unadvanced address, err=1 until reset. With MIPS_ENC_CHECK_EN: R-type with opcode=35 -> dropped, err=1.
- Reset mid-FULL with out_ready=0 -> next cycle out_valid=0, in_ready=1, next word at BASE_ADDR.
